// File: rtl/rom_read_master.sv
// rtl/rom_read_master.sv - block read engine on the req/grant/rvalid 64-bit bus
// Streams num_words words from base_addr onward through a credit-protected output FIFO.
module rom_read_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [63:0]      base_addr_i,
  input  logic [CNT_W-1:0] num_words_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             protocol_err_o,
  output logic             req_o,
  output logic [63:0]      address_o,
  input  logic             grant_i,
  input  logic             rvalid_i,
  input  logic [63:0]      data_i,
  output logic [63:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [63:0]      addr_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] returned_q;
  logic [CW-1:0]    out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic             err_q;
  logic             arm_q;

  logic             grant_acc;
  logic             push;
  logic             pop;
  logic             spurious;
  logic [CNT_W:0]   issued_nx;
  logic             credit_ok;

  assign grant_acc = req_q & grant_i;
  assign push      = rvalid_i & (out_q != '0);
  assign spurious  = rvalid_i & (out_q == '0);
  assign pop       = (cnt_q != '0) & ready_i;
  assign out_d     = out_q + CW'(grant_acc) - CW'(push);
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign issued_nx = {1'b0, issued_q} + (CNT_W+1)'(grant_acc);
  // A new request may only go out if its data is guaranteed a FIFO slot.
  assign credit_ok = ({1'b0, out_d} + {1'b0, cnt_d}) < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // A zero-length transfer still spends one busy cycle in DRAIN.
          state_d = (num_words_i == '0) ? S_DRAIN : S_ISSUE;
          req_d   = (num_words_i != '0);
        end
      end
      S_ISSUE: begin
        if (grant_acc && (issued_nx == {1'b0, num_q})) begin
          state_d = S_DRAIN;
        end else if (req_q && !grant_i) begin
          req_d = 1'b1;
        end else begin
          req_d = (issued_nx < {1'b0, num_q}) && credit_ok;
        end
      end
      S_DRAIN: begin
        if ((returned_q == num_q) && (cnt_d == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if ((state_q == S_IDLE) && start_i) begin
        addr_q     <= base_addr_i & ~64'h7;
        num_q      <= num_words_i;
        issued_q   <= '0;
        returned_q <= '0;
        err_q      <= 1'b0;
        arm_q      <= 1'b1;
      end else begin
        if (grant_acc) begin
          addr_q   <= addr_q + 64'd8;
          issued_q <= issued_nx[CNT_W-1:0];
        end
        if (push) returned_q <= returned_q + CNT_W'(1);
        // Responses still in flight from before a reset are not errors.
        if (spurious && arm_q) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign busy_o         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o         = (state_q == S_DONE);
  assign protocol_err_o = err_q;
  assign req_o          = req_q;
  assign address_o      = addr_q;
  assign valid_o        = (cnt_q != '0);
  assign data_o         = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_rom_read_master.sv
// tb/tb_rom_read_master.sv - bench for rom_read_master
// Randomized slave and sink checked against a word-list model of the ROM.
module tb_rom_read_master;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [63:0] base_addr_i;
  logic [15:0] num_words_i;
  logic        busy_o, done_o, protocol_err_o, req_o, valid_o;
  logic [63:0] address_o, data_o, data_i;
  logic        grant_i, rvalid_i, ready_i;

  rom_read_master #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o),
    .protocol_err_o(protocol_err_o), .req_o(req_o), .address_o(address_o),
    .grant_i(grant_i), .rvalid_i(rvalid_i), .data_i(data_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  typedef struct {int due; logic [63:0] data;} resp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          t0    = 0;
  resp_t       pend[$];
  int          gl_cyc[$];
  logic [63:0] gl_addr[$];
  int          hs_cyc[$];
  logic [63:0] hs_data[$];
  int          last_due = 0;
  int          wait_left = 0;
  int          gnt_wait_max = 0;
  int          rv_lat_min = 0;
  int          rv_lat_extra = 0;
  bit          ready_force0 = 0;
  bit          ready_rand = 0;
  bit          mon_en = 1;
  bit          inject_spur = 0;
  bit          done_seen = 0;
  int          done_rel = -1;
  int          busy_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rom_word(input logic [63:0] a);
    case (a)
      64'h1000: rom_word = 64'h02028593_00000297;
      64'h1008: rom_word = 64'h0182b283_f1402573;
      64'h1010: rom_word = 64'h00028067_0202b583;
      64'h1018: rom_word = 64'h00000000_80000000;
      default:  rom_word = {a[31:0] ^ 32'h5a5a_c3c3, ~a[63:32] ^ a[31:0]};
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave, sink and protocol monitor, all acting on the falling edge.
  initial begin
    int          rel, lat, due;
    bit          prev_rng, prev_vnr;
    logic [63:0] prev_addr, prev_data;
    prev_rng = 0;
    prev_vnr = 0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      rel = cyc - t0;
      if (mon_en && rst_ni && prev_rng) begin
        check("req_hold", req_o, 1);
        check("addr_hold", address_o, prev_addr);
      end
      if (mon_en && rst_ni && prev_vnr) begin
        check("valid_hold", valid_o, 1);
        check("data_hold", data_o, prev_data);
      end
      grant_i = 1'b0;
      if (mon_en && req_o) begin
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          grant_i = 1'b1;
          lat = rv_lat_min + ((rv_lat_extra > 0) ? int'($urandom_range(0, rv_lat_extra)) : 0);
          due = cyc + 1 + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{due: due, data: rom_word(address_o)});
          gl_cyc.push_back(rel);
          gl_addr.push_back(address_o);
          wait_left = (gnt_wait_max > 0) ? int'($urandom_range(0, gnt_wait_max)) : 0;
        end
      end
      prev_rng  = mon_en && rst_ni && req_o && !grant_i;
      prev_addr = address_o;
      rvalid_i = 1'b0;
      if (inject_spur) begin
        rvalid_i = 1'b1;
        data_i = 64'hbad0_bad0_bad0_bad0;
        inject_spur = 0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        rvalid_i = 1'b1;
        data_i = pend[0].data;
        void'(pend.pop_front());
      end
      ready_i = ready_force0 ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (mon_en && valid_o && ready_i) begin
        hs_cyc.push_back(rel);
        hs_data.push_back(data_o);
      end
      prev_vnr  = mon_en && rst_ni && valid_o && !ready_i;
      prev_data = data_o;
      if (done_o) begin
        done_seen = 1;
        done_rel = rel;
      end
      if (busy_o) busy_cnt++;
    end
  end

  task automatic start_xfer(input logic [63:0] base, input int num);
    @(negedge clk);
    gl_cyc.delete(); gl_addr.delete(); hs_cyc.delete(); hs_data.delete();
    done_seen = 0; done_rel = -1; busy_cnt = 0;
    t0 = cyc;
    start_i = 1'b1;
    base_addr_i = base;
    num_words_i = 16'(num);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && !done_seen; i++) @(negedge clk);
    check("done_seen", done_seen, 1);
  endtask

  task automatic check_data(input logic [63:0] base, input int num);
    logic [63:0] a;
    check("word_count", hs_data.size(), num);
    a = base & ~64'h7;
    for (int i = 0; i < num && i < hs_data.size(); i++) begin
      check($sformatf("word%0d", i), hs_data[i], rom_word(a));
      a = a + 64'd8;
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"}, busy_o, 0);
    check({pfx, "_done"}, done_o, 0);
    check({pfx, "_err"}, protocol_err_o, 0);
    check({pfx, "_req"}, req_o, 0);
    check({pfx, "_addr"}, address_o, 0);
    check({pfx, "_valid"}, valid_o, 0);
    check({pfx, "_data"}, data_o, 0);
  endtask

  initial begin
    logic [63:0] b;
    int          n;
    rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    grant_i = 1'b0; rvalid_i = 1'b0; data_i = '0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Boot ROM read with exact cycle timing.
    start_xfer(64'h1000, 4);
    wait_done(50);
    check("boot_grants", gl_cyc.size(), 4);
    for (int i = 0; i < 4 && i < gl_cyc.size(); i++) begin
      check($sformatf("boot_req_cyc%0d", i), gl_cyc[i], i + 1);
      check($sformatf("boot_addr%0d", i), gl_addr[i], 64'h1000 + 64'(8 * i));
    end
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++)
      check($sformatf("boot_valid_cyc%0d", i), hs_cyc[i], i + 3);
    check_data(64'h1000, 4);
    check("boot_done_cyc", done_rel, 7);

    // Zero-length transfer.
    start_xfer(64'h1000, 0);
    wait_done(20);
    check("zero_grants", gl_cyc.size(), 0);
    check("zero_busy_cycles", busy_cnt, 1);
    check("zero_done_cyc", done_rel, 2);

    // Unaligned base is masked.
    start_xfer(64'h1004, 1);
    wait_done(50);
    check("mask_addr", (gl_addr.size() > 0) ? gl_addr[0] : 64'hx, 64'h1000);
    check_data(64'h1004, 1);

    // Backpressure: credits must cap grants at the FIFO depth.
    ready_force0 = 1;
    start_xfer(64'h2000, 10);
    repeat (20) @(negedge clk);
    check("bp_grants", gl_cyc.size(), 4);
    check("bp_req_low", req_o, 0);
    check("bp_no_output", hs_data.size(), 0);
    ready_force0 = 0;
    wait_done(200);
    check_data(64'h2000, 10);

    // Address wrap at the top of the space.
    start_xfer(64'hFFFF_FFFF_FFFF_FFF8, 2);
    wait_done(50);
    check("wrap_grants", gl_addr.size(), 2);
    if (gl_addr.size() == 2) begin
      check("wrap_addr0", gl_addr[0], 64'hFFFF_FFFF_FFFF_FFF8);
      check("wrap_addr1", gl_addr[1], 64'h0);
    end
    check_data(64'hFFFF_FFFF_FFFF_FFF8, 2);

    // Randomized slave timing and sink backpressure.
    gnt_wait_max = 3; rv_lat_extra = 3; ready_rand = 1;
    for (int k = 0; k < 5; k++) begin
      b = {$urandom, $urandom};
      n = int'($urandom_range(1, 40));
      start_xfer(b, n);
      wait_done(2000);
      check_data(b, n);
    end
    gnt_wait_max = 0; rv_lat_extra = 0; ready_rand = 0;

    // Spurious rvalid while idle.
    repeat (3) @(negedge clk);
    inject_spur = 1;
    repeat (3) @(negedge clk);
    check("spur_err", protocol_err_o, 1);
    check("spur_fifo_empty", valid_o, 0);
    start_xfer(64'h3000, 2);
    check("spur_err_cleared", protocol_err_o, 0);
    wait_done(50);
    check_data(64'h3000, 2);

    // Reset in the middle of a transfer with reads still in flight.
    rv_lat_min = 2;
    start_xfer(64'h4000, 8);
    for (int i = 0; i < 200 && hs_data.size() < 3; i++) @(negedge clk);
    check("pre_reset_words", hs_data.size() >= 3, 1);
    mon_en = 0;
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1;
    for (int i = 0; i < 100 && pend.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("post_rst_err", protocol_err_o, 0);
    check("post_rst_valid", valid_o, 0);
    check("post_rst_busy", busy_o, 0);
    rv_lat_min = 0;
    start_xfer(64'h5000, 5);
    wait_done(100);
    check_data(64'h5000, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
